// File: rtl/mem_access_ctrl.sv
// Initiator side of the four-phase RAM memory-function handshake.
// Optional accept-time alignment check enabled by defining MISALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqRW,
    input  logic [8:0]  reqAddr,
    input  logic [31:0] reqData,
    input  logic [1:0]  reqSize,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respError,
    output logic        memFuncActive,
    output logic        readWrite,
    output logic [8:0]  address,
    output logic [31:0] dataIn,
    output logic [1:0]  dataSize,
    input  logic [31:0] dataOut,
    input  logic        memFuncComplete
);

    typedef enum logic [1:0] {StIdle, StWait, StRelease, StResp} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        rw_q, rw_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        bad_size;
    logic        misalign;
    logic [31:0] rdata_masked;

    assign accept   = reqValid && (state_q == StIdle);
    assign bad_size = (reqSize == 2'b10);

`ifdef MISALIGN_CHECK_EN
    assign misalign = ((reqSize == 2'b01) && reqAddr[0]) ||
                      ((reqSize == 2'b11) && (reqAddr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        rdata_masked = dataOut;
        case (size_q)
            2'b00:   rdata_masked = {24'h0, dataOut[7:0]};
            2'b01:   rdata_masked = {16'h0, dataOut[15:0]};
            default: rdata_masked = dataOut;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    rw_d    = reqRW;
                    addr_d  = reqAddr;
                    wdata_d = reqData;
                    size_d  = reqSize;
                    cnt_d   = 8'd0;
                    if (bad_size || misalign) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                // Completion takes priority over a timeout on the same edge.
                if (memFuncComplete) begin
                    if (!rw_q) rdata_d = rdata_masked;
                    state_d = StRelease;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRelease: begin
                if (!memFuncComplete) state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= 9'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    // Decoded from the state register so an async reset drops memFuncActive at once.
    assign reqReady      = (state_q == StIdle);
    assign memFuncActive = (state_q == StWait);
    assign respValid     = (state_q == StResp);
    assign respError     = (state_q == StResp) && err_q;
    assign respData      = rdata_q;
    assign readWrite     = rw_q;
    assign address       = addr_q;
    assign dataIn        = wdata_q;
    assign dataSize      = size_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table plus randomized requests checked
// against a byte-array reference model, with a simple RAM responder.
module tb_mem_access_ctrl;

    localparam int unsigned TO = 4;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        reqValid;
    logic        reqReady;
    logic        reqRW;
    logic [8:0]  reqAddr;
    logic [31:0] reqData;
    logic [1:0]  reqSize;
    logic        respValid;
    logic [31:0] respData;
    logic        respError;
    logic        memFuncActive;
    logic        readWrite;
    logic [8:0]  address;
    logic [31:0] dataIn;
    logic [1:0]  dataSize;
    logic [31:0] dataOut = 32'hDEADBEEF;
    logic        memFuncComplete = 1'b0;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .reqValid        (reqValid),
        .reqReady        (reqReady),
        .reqRW           (reqRW),
        .reqAddr         (reqAddr),
        .reqData         (reqData),
        .reqSize         (reqSize),
        .respValid       (respValid),
        .respData        (respData),
        .respError       (respError),
        .memFuncActive   (memFuncActive),
        .readWrite       (readWrite),
        .address         (address),
        .dataIn          (dataIn),
        .dataSize        (dataSize),
        .dataOut         (dataOut),
        .memFuncComplete (memFuncComplete)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // RAM responder: raises MFC mfc_delay negedges after seeing memFuncActive, drops it
    // mfc_hold negedges after memFuncActive falls.
    int         mfc_delay = 1;
    int         mfc_hold  = 0;
    bit         mfc_never = 1'b0;
    logic [7:0] ram_mem[512];
    bit         ram_ready = 1'b0;
    int         ram_cnt = 0;
    int         ram_hold = 0;

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    always @(negedge Clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 512; i++) ram_mem[i] = 8'((i * 7 + 3) % 256);
            ram_ready = 1'b1;
        end
        if (Reset_n !== 1'b1) begin
            memFuncComplete = 1'b0;
            ram_cnt  = 0;
            ram_hold = 0;
        end else if (memFuncActive && !memFuncComplete) begin
            if (!mfc_never) begin
                ram_cnt++;
                if (ram_cnt >= mfc_delay) begin
                    if (readWrite) begin
                        for (int i = 0; i < size_bytes(dataSize); i++)
                            ram_mem[(int'(address) + i) % 512] = dataIn[8*i +: 8];
                    end else begin
                        for (int i = 0; i < 4; i++)
                            dataOut[8*i +: 8] = ram_mem[(int'(address) + i) % 512];
                    end
                    memFuncComplete = 1'b1;
                    ram_cnt  = 0;
                    ram_hold = 0;
                end
            end
        end else if (memFuncComplete && !memFuncActive) begin
            if (ram_hold >= mfc_hold) memFuncComplete = 1'b0;
            else ram_hold++;
        end
    end

    // Reference model: byte-addressed memory image plus the last good read value.
    logic [7:0]  ref_mem[512];
    logic [31:0] exp_rdata = 32'h0;

    task automatic predict(input bit rw, input logic [8:0] addr, input logic [31:0] data,
                           input logic [1:0] size, input int delay, input int hold,
                           input bit never, output bit err, output int lat,
                           output bit access);
        bit bad;
        bad = (size == 2'b10);
`ifdef MISALIGN_CHECK_EN
        if (size == 2'b01 && addr % 2 != 0) bad = 1'b1;
        if (size == 2'b11 && addr % 4 != 0) bad = 1'b1;
`endif
        if (bad) begin
            err = 1'b1; lat = 0; access = 1'b0;
        end else if (never) begin
            err = 1'b1; lat = TO + 2; access = 1'b1;
        end else begin
            err = 1'b0; lat = delay + 1 + hold; access = 1'b1;
            if (rw) begin
                for (int i = 0; i < size_bytes(size); i++)
                    ref_mem[(int'(addr) + i) % 512] = data[8*i +: 8];
            end else begin
                exp_rdata = 32'h0;
                for (int i = 0; i < size_bytes(size); i++)
                    exp_rdata[8*i +: 8] = ref_mem[(int'(addr) + i) % 512];
            end
        end
    endtask

    // Latency = number of rising edges after the accept edge before respValid is seen.
    task automatic run_txn(input string tag, input bit rw, input logic [8:0] addr,
                           input logic [31:0] data, input logic [1:0] size, input int delay,
                           input int hold, input bit never, input bit e_err, input int e_lat,
                           input logic [31:0] e_rdata, input bit e_access);
        int k;
        bit got, saw, stable;
        mfc_delay = delay;
        mfc_hold  = hold;
        mfc_never = never;
        @(negedge Clk);
        check({tag, ".ready"}, reqReady, 1'b1);
        reqValid = 1'b1; reqRW = rw; reqAddr = addr; reqData = data; reqSize = size;
        @(posedge Clk);
        #1;
        reqValid = 1'b0;
        reqRW = 1'($urandom); reqAddr = 9'($urandom);
        reqData = $urandom; reqSize = 2'($urandom);
        k = 0; got = 1'b0; saw = 1'b0; stable = 1'b1;
        while (!got && k <= 40) begin
            if (memFuncActive) begin
                saw = 1'b1;
                if (address !== addr || readWrite !== rw || dataIn !== data || dataSize !== size)
                    stable = 1'b0;
            end
            if (respValid) begin
                got = 1'b1;
                check({tag, ".latency"}, k, e_lat);
                check({tag, ".err"}, respError, e_err);
                check({tag, ".rdata"}, respData, e_rdata);
                check({tag, ".mfa_low_at_resp"}, memFuncActive, 1'b0);
            end else begin
                @(posedge Clk);
                #1;
                k++;
            end
        end
        if (!got) check({tag, ".resp_seen"}, 1'b0, 1'b1);
        check({tag, ".ram_accessed"}, saw, e_access);
        if (e_access) check({tag, ".ram_side_stable"}, stable, 1'b1);
        @(posedge Clk);
        #1;
        check({tag, ".single_pulse"}, respValid, 1'b0);
        check({tag, ".ready_after"}, reqReady, 1'b1);
    endtask

    typedef struct {
        bit          rw;
        logic [8:0]  addr;
        logic [31:0] data;
        logic [1:0]  size;
        int          delay;
        int          hold;
        bit          never;
        bit          e_err;
        int          e_lat;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit   m_err, m_acc;
        int   m_lat;
        bit   rw, never, pulse;
        logic [8:0]  addr;
        logic [1:0]  size;
        logic [31:0] data;
        int   delay, hold, r;

        for (int i = 0; i < 512; i++) ref_mem[i] = 8'((i * 7 + 3) % 256);

        vecs[0] = '{1, 9'd0, 32'hAABBCCDD, 2'b11, 3, 0, 0, 0, 4, 32'h00000000};
        vecs[1] = '{0, 9'd0, 32'h0,        2'b11, 3, 0, 0, 0, 4, 32'hAABBCCDD};
        vecs[2] = '{1, 9'd4, 32'h11EEFFAA, 2'b01, 3, 0, 0, 0, 4, 32'hAABBCCDD};
        vecs[3] = '{0, 9'd4, 32'h0,        2'b01, 3, 0, 0, 0, 4, 32'h0000FFAA};
        vecs[4] = '{1, 9'd6, 32'h11EEFF22, 2'b00, 3, 0, 0, 0, 4, 32'h0000FFAA};
        vecs[5] = '{0, 9'd6, 32'h0,        2'b00, 1, 0, 0, 0, 2, 32'h00000022};
        vecs[6] = '{0, 9'd8, 32'h0,        2'b10, 1, 0, 0, 1, 0, 32'h00000022};
        vecs[7] = '{0, 9'd0, 32'h0,        2'b11, 1, 0, 1, 1, 6, 32'h00000022};
        vecs[8] = '{0, 9'd0, 32'h0,        2'b11, 2, 5, 0, 0, 8, 32'hAABBCCDD};
`ifdef MISALIGN_CHECK_EN
        vecs[9] = '{0, 9'd2, 32'h0,        2'b11, 1, 0, 0, 1, 0, 32'hAABBCCDD};
`else
        vecs[9] = '{0, 9'd2, 32'h0,        2'b11, 1, 0, 0, 0, 2, 32'hFFAAAABB};
`endif

        Reset_n = 1'b0;
        reqValid = 1'b0; reqRW = 1'b0; reqAddr = 9'd0; reqData = 32'd0; reqSize = 2'd0;
        #12;
        check("rst.reqReady", reqReady, 1'b1);
        check("rst.memFuncActive", memFuncActive, 1'b0);
        check("rst.readWrite", readWrite, 1'b0);
        check("rst.address", address, 32'd0);
        check("rst.dataIn", dataIn, 32'd0);
        check("rst.dataSize", dataSize, 32'd0);
        check("rst.respValid", respValid, 1'b0);
        check("rst.respError", respError, 1'b0);
        check("rst.respData", respData, 32'd0);
        #4 Reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            predict(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].delay,
                    vecs[i].hold, vecs[i].never, m_err, m_lat, m_acc);
            run_txn($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].data,
                    vecs[i].size, vecs[i].delay, vecs[i].hold, vecs[i].never,
                    vecs[i].e_err, vecs[i].e_lat, vecs[i].e_rdata, m_acc);
        end

        // Reset mid-WAIT: handshake dropped immediately, no response pulse.
        mfc_never = 1'b1;
        @(negedge Clk);
        reqValid = 1'b1; reqRW = 1'b0; reqAddr = 9'd16; reqSize = 2'b11;
        @(posedge Clk);
        #1 reqValid = 1'b0;
        @(posedge Clk);
        #1;
        check("rstwait.mfa_before", memFuncActive, 1'b1);
        Reset_n = 1'b0;
        #1;
        check("rstwait.mfa", memFuncActive, 1'b0);
        check("rstwait.ready", reqReady, 1'b1);
        check("rstwait.respValid", respValid, 1'b0);
        check("rstwait.respData", respData, 32'd0);
        exp_rdata = 32'h0;
        #6 Reset_n = 1'b1;
        pulse = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk);
            #1;
            if (respValid || memFuncActive) pulse = 1'b1;
        end
        check("rstwait.quiet", pulse, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rw = 1'($urandom);
            r = $urandom_range(0, 9);
            size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
            addr = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'b01) addr[0] = 1'b0;
                if (size == 2'b11) addr[1:0] = 2'b00;
            end
            data  = $urandom;
            delay = $urandom_range(1, 5);
            hold  = $urandom_range(0, 3);
            never = ($urandom_range(0, 9) == 0);
            predict(rw, addr, data, size, delay, hold, never, m_err, m_lat, m_acc);
            run_txn($sformatf("rnd%0d", n), rw, addr, data, size, delay, hold, never,
                    m_err, m_lat, exp_rdata, m_acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
